ucsbece154b_branch_gshare: RTL and testbench

Parametrised next-generation branch predictor for the 5-stage RV32I pipeline. It provides same-cycle fetch prediction from a tagged BTB, a gshare PHT of 2-bit counters, a speculatively updated GHR and a return-address stack (RAS). Execute-stage resolution trains the BTB and PHT and repairs the GHR on mispredict. The datapath instantiates it in fetch and feeds resolve signals from EX.

---
 rtl/ucsbece154b_branch_gshare_pkg.sv | 28 ++
 rtl/ucsbece154b_ras.sv | 42 ++++
 rtl/ucsbece154b_branch_gshare.sv | 162 ++++++++++++++++
 tb/tb_ucsbece154b_branch_gshare.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_branch_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor: branch type encodings,
// PHT counter width/reset value and the saturating counter update.
package ucsbece154b_branch_gshare_pkg;

    typedef enum logic [1:0] {
        BrCond = 2'b00,
        BrJump = 2'b01,
        BrCall = 2'b10,
        BrRet  = 2'b11
    } brType_t;

    localparam int unsigned CtrWidth = 2;
    localparam logic [CtrWidth-1:0] PhtResetVal = 2'b01;
    localparam logic [31:0] InstrBytes = 32'd4;

    function automatic logic [CtrWidth-1:0] ctrNext(input logic [CtrWidth-1:0] ctr,
                                                    input logic taken);
        logic [CtrWidth-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != '1) res = ctr + 1'b1;
        end else begin
            if (ctr != '0) res = ctr - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored.
module ucsbece154b_ras #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] pushData_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]     mem [DEPTH];
    logic [PtrW-1:0] ptr;   // next free slot; top lives at ptr-1
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push_i) begin
            ptr <= ptr + 1'b1;
            if (cnt != CntW'(DEPTH)) cnt <= cnt + 1'b1;
        end else if (pop_i && (cnt != '0)) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[ptr] <= pushData_i;
    end

    assign top_o   = mem[ptr - 1'b1];
    assign empty_o = (cnt == '0);

endmodule

// File: rtl/ucsbece154b_branch_gshare.sv
// Fetch-stage branch predictor: tagged BTB, gshare PHT of 2-bit counters,
// speculative GHR with EX-stage repair, and a return-address stack.
module ucsbece154b_branch_gshare
    import ucsbece154b_branch_gshare_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 6,
    parameter int unsigned NUM_RAS_ENTRIES = 4,
    parameter int unsigned TAG_BITS        = 8
) (
    input  logic                    clk,
    input  logic                    reset_i,

    input  logic [31:0]             pc_f_i,
    input  logic                    fetch_adv_f_i,
    output logic                    pred_taken_f_o,
    output logic [31:0]             pred_target_f_o,
    output logic [NUM_GHR_BITS-1:0] pred_idx_f_o,
    output logic [NUM_GHR_BITS-1:0] pred_ghr_f_o,

    input  logic                    res_valid_e_i,
    input  logic [31:0]             res_pc_e_i,
    input  logic [1:0]              res_type_e_i,
    input  logic                    res_taken_e_i,
    input  logic [31:0]             res_target_e_i,
    input  logic [NUM_GHR_BITS-1:0] res_idx_e_i,
    input  logic [NUM_GHR_BITS-1:0] res_ghr_e_i,
    input  logic                    res_mispred_e_i
);

    localparam int unsigned BtbIdxW  = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned PhtDepth = 2 ** NUM_GHR_BITS;

    // BTB storage; only the valid bits need a reset
    logic [NUM_BTB_ENTRIES-1:0] btbValid;
    logic [TAG_BITS-1:0]        btbTag    [NUM_BTB_ENTRIES];
    brType_t                    btbType   [NUM_BTB_ENTRIES];
    logic [31:0]                btbTarget [NUM_BTB_ENTRIES];

    logic [CtrWidth-1:0]     pht [PhtDepth];
    logic [NUM_GHR_BITS-1:0] ghr, ghrNext;

    logic [BtbIdxW-1:0]      btbIdxF, btbIdxE;
    logic [TAG_BITS-1:0]     tagF, tagE;
    logic [NUM_GHR_BITS-1:0] phtIdxF;
    logic                    btbHit, fetchHit, condTaken;
    brType_t                 hitType, resType;
    logic [31:0]             hitTarget, pcPlus4;

    logic                    rasPush, rasPop, rasEmpty;
    logic [31:0]             rasTop;

    logic                    btbWe, phtWe, ghrRepair;
    logic                    unusedResPc;

    // Fetch-side lookup
    assign btbIdxF   = pc_f_i[BtbIdxW+1:2];
    assign tagF      = pc_f_i[BtbIdxW+TAG_BITS+1:BtbIdxW+2];
    assign phtIdxF   = pc_f_i[NUM_GHR_BITS+1:2] ^ ghr;
    assign pcPlus4   = pc_f_i + InstrBytes;
    assign btbHit    = btbValid[btbIdxF] && (btbTag[btbIdxF] == tagF);
    assign hitType   = btbType[btbIdxF];
    assign hitTarget = btbTarget[btbIdxF];
    assign condTaken = pht[phtIdxF][CtrWidth-1];
    assign fetchHit  = fetch_adv_f_i && btbHit;

    always_comb begin
        pred_taken_f_o  = 1'b0;
        pred_target_f_o = pcPlus4;
        if (btbHit) begin
            unique case (hitType)
                BrCond: begin
                    pred_taken_f_o = condTaken;
                    if (condTaken) pred_target_f_o = hitTarget;
                end
                BrJump, BrCall: begin
                    pred_taken_f_o  = 1'b1;
                    pred_target_f_o = hitTarget;
                end
                BrRet: begin
                    pred_taken_f_o  = 1'b1;
                    pred_target_f_o = rasEmpty ? hitTarget : rasTop;
                end
                default: ;
            endcase
        end
    end

    assign pred_idx_f_o = phtIdxF;
    assign pred_ghr_f_o = ghr;

    assign rasPush = fetchHit && (hitType == BrCall);
    assign rasPop  = fetchHit && (hitType == BrRet);

    ucsbece154b_ras #(
        .DEPTH(NUM_RAS_ENTRIES)
    ) u_ras (
        .clk        (clk),
        .reset_i    (reset_i),
        .push_i     (rasPush),
        .pop_i      (rasPop),
        .pushData_i (pcPlus4),
        .top_o      (rasTop),
        .empty_o    (rasEmpty)
    );

    // Resolve-side training
    assign btbIdxE     = res_pc_e_i[BtbIdxW+1:2];
    assign tagE        = res_pc_e_i[BtbIdxW+TAG_BITS+1:BtbIdxW+2];
    assign resType     = brType_t'(res_type_e_i);
    assign btbWe       = res_valid_e_i && res_taken_e_i;
    assign phtWe       = res_valid_e_i && (resType == BrCond);
    assign ghrRepair   = res_valid_e_i && res_mispred_e_i;
    assign unusedResPc = ^res_pc_e_i;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            btbValid <= '0;
        end else if (btbWe) begin
            btbValid[btbIdxE] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btbWe) begin
            btbTag[btbIdxE]    <= tagE;
            btbType[btbIdxE]   <= resType;
            btbTarget[btbIdxE] <= res_target_e_i;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < PhtDepth; i++) pht[i] <= PhtResetVal;
        end else if (phtWe) begin
            pht[res_idx_e_i] <= ctrNext(pht[res_idx_e_i], res_taken_e_i);
        end
    end

    // A resolved mispredict outranks the speculative shift from this cycle's fetch
    always_comb begin
        ghrNext = ghr;
        if (ghrRepair) begin
            if (resType == BrCond) begin
                ghrNext = {res_ghr_e_i[NUM_GHR_BITS-2:0], res_taken_e_i};
            end else begin
                ghrNext = res_ghr_e_i;
            end
        end else if (fetchHit && (hitType == BrCond)) begin
            ghrNext = {ghr[NUM_GHR_BITS-2:0], condTaken};
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            ghr <= '0;
        end else begin
            ghr <= ghrNext;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_branch_gshare.sv
// Scoreboard bench for the gshare predictor: a queue/array reference model predicts each
// fetch-cycle output, a negedge monitor pops and compares.
module tb_ucsbece154b_branch_gshare;

    localparam int NB = 32;
    localparam int NG = 6;
    localparam int NR = 4;
    localparam int IdxBits = 5;
    localparam int TagMod = 256;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [31:0]   pc_f_i;
    logic          fetch_adv_f_i;
    logic          pred_taken_f_o;
    logic [31:0]   pred_target_f_o;
    logic [NG-1:0] pred_idx_f_o;
    logic [NG-1:0] pred_ghr_f_o;
    logic          res_valid_e_i;
    logic [31:0]   res_pc_e_i;
    logic [1:0]    res_type_e_i;
    logic          res_taken_e_i;
    logic [31:0]   res_target_e_i;
    logic [NG-1:0] res_idx_e_i;
    logic [NG-1:0] res_ghr_e_i;
    logic          res_mispred_e_i;

    always #5 clk = ~clk;

    ucsbece154b_branch_gshare #(
        .NUM_BTB_ENTRIES(NB),
        .NUM_GHR_BITS   (NG),
        .NUM_RAS_ENTRIES(NR),
        .TAG_BITS       (8)
    ) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .pc_f_i          (pc_f_i),
        .fetch_adv_f_i   (fetch_adv_f_i),
        .pred_taken_f_o  (pred_taken_f_o),
        .pred_target_f_o (pred_target_f_o),
        .pred_idx_f_o    (pred_idx_f_o),
        .pred_ghr_f_o    (pred_ghr_f_o),
        .res_valid_e_i   (res_valid_e_i),
        .res_pc_e_i      (res_pc_e_i),
        .res_type_e_i    (res_type_e_i),
        .res_taken_e_i   (res_taken_e_i),
        .res_target_e_i  (res_target_e_i),
        .res_idx_e_i     (res_idx_e_i),
        .res_ghr_e_i     (res_ghr_e_i),
        .res_mispred_e_i (res_mispred_e_i)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        bit          checkTarget;
        int          idx;
        int          ghr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    bit          mValid [NB];
    int          mTag   [NB];
    int          mType  [NB];
    logic [31:0] mTarget[NB];
    int          mPht   [2**NG];
    int          mGhr;
    logic [31:0] mRas[$];

    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp("pred_taken", {31'd0, pred_taken_f_o}, {31'd0, e.taken});
            cmp("pred_idx", {26'd0, pred_idx_f_o}, 32'(e.idx));
            cmp("pred_ghr", {26'd0, pred_ghr_f_o}, 32'(e.ghr));
            if (e.checkTarget) cmp("pred_target", pred_target_f_o, e.target);
        end
    end

    function automatic int btbIdx(input logic [31:0] pc);
        return int'((pc >> 2) % NB);
    endfunction

    function automatic int btbTag(input logic [31:0] pc);
        return int'((pc >> (2 + IdxBits)) % TagMod);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NB; i++) mValid[i] = 1'b0;
        for (int i = 0; i < 2**NG; i++) mPht[i] = 1;
        mGhr = 0;
        mRas.delete();
    endtask

    task automatic predict(input logic [31:0] pc, output exp_t e, output bit hit,
                           output int typ);
        int i;
        i      = btbIdx(pc);
        hit    = mValid[i] && (mTag[i] == btbTag(pc));
        typ    = mType[i];
        e.idx  = int'((pc >> 2) % (2**NG)) ^ mGhr;
        e.ghr  = mGhr;
        e.taken = 1'b0;
        e.target = pc + 32'd4;
        e.checkTarget = 1'b1;
        if (hit) begin
            if (typ == 0) begin
                e.taken = (mPht[e.idx] >= 2);
                e.target = mTarget[i];
                e.checkTarget = e.taken;
            end else if (typ == 3 && mRas.size() > 0) begin
                e.taken = 1'b1;
                e.target = mRas[mRas.size()-1];
            end else begin
                e.taken = 1'b1;
                e.target = mTarget[i];
            end
        end
    endtask

    task automatic setRes(input bit v, input logic [31:0] pc, input int typ, input bit taken,
                          input logic [31:0] tgt, input int idx, input int ghr, input bit mis);
        res_valid_e_i   = v;
        res_pc_e_i      = pc;
        res_type_e_i    = typ[1:0];
        res_taken_e_i   = (typ != 0) ? 1'b1 : taken;
        res_target_e_i  = tgt;
        res_idx_e_i     = idx[NG-1:0];
        res_ghr_e_i     = ghr[NG-1:0];
        res_mispred_e_i = mis;
    endtask

    // Drive one fetch cycle (resolve inputs already set), record expectation, advance model
    task automatic step(input logic [31:0] pc, input bit adv);
        exp_t e;
        bit   hit;
        int   typ;
        int   newGhr;
        int   rt;
        int   ri;
        pc_f_i = pc;
        fetch_adv_f_i = adv;
        predict(pc, e, hit, typ);
        expQ.push_back(e);
        newGhr = mGhr;
        if (adv && hit) begin
            if (typ == 0) begin
                newGhr = ((mGhr << 1) | int'(e.taken)) % (2**NG);
            end else if (typ == 2) begin
                mRas.push_back(pc + 32'd4);
                if (mRas.size() > NR) mRas.delete(0);
            end else if (typ == 3) begin
                if (mRas.size() > 0) mRas.delete(mRas.size() - 1);
            end
        end
        rt = int'(res_type_e_i);
        if (res_valid_e_i && res_mispred_e_i) begin
            newGhr = (rt == 0) ? ((int'(res_ghr_e_i) << 1) | int'(res_taken_e_i)) % (2**NG)
                               : int'(res_ghr_e_i);
        end
        if (res_valid_e_i && res_taken_e_i) begin
            ri = btbIdx(res_pc_e_i);
            mValid[ri] = 1'b1;
            mTag[ri] = btbTag(res_pc_e_i);
            mType[ri] = rt;
            mTarget[ri] = res_target_e_i;
        end
        if (res_valid_e_i && rt == 0) begin
            ri = int'(res_idx_e_i);
            if (res_taken_e_i) mPht[ri] = (mPht[ri] == 3) ? 3 : mPht[ri] + 1;
            else               mPht[ri] = (mPht[ri] == 0) ? 0 : mPht[ri] - 1;
        end
        mGhr = newGhr;
        @(posedge clk);
        #1;
        res_valid_e_i = 1'b0;
    endtask

    task automatic idleRes();
        setRes(1'b0, 32'd0, 0, 1'b0, 32'd0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_i = 1'b0;
        pc_f_i = 32'h100;
        fetch_adv_f_i = 1'b0;
        idleRes();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b1;

        // Reset state
        step(32'h100, 1'b1);

        // Cond branch training and PHT saturation down to 0
        setRes(1'b1, 32'h100, 0, 1'b1, 32'h80, 0, 0, 1'b0);
        step(32'h100, 1'b0);
        step(32'h100, 1'b0);
        setRes(1'b1, 32'h100, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        step(32'h100, 1'b0);
        setRes(1'b1, 32'h100, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        step(32'h100, 1'b0);
        setRes(1'b1, 32'h100, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        step(32'h100, 1'b0);
        step(32'h100, 1'b0);

        // Call then return
        setRes(1'b1, 32'h200, 2, 1'b1, 32'h400, 0, 0, 1'b0);
        step(32'h40, 1'b0);
        step(32'h200, 1'b1);
        setRes(1'b1, 32'h300, 3, 1'b1, 32'h500, 0, 0, 1'b0);
        step(32'h40, 1'b0);
        step(32'h300, 1'b1);
        step(32'h300, 1'b0);

        // Five pushes into a 4-deep RAS, then five returns
        for (int k = 0; k < 5; k++) begin
            setRes(1'b1, 32'h208 + 32'(4 * k), 2, 1'b1, 32'h600, 0, 0, 1'b0);
            step(32'h40, 1'b0);
        end
        for (int k = 0; k < 5; k++) step(32'h208 + 32'(4 * k), 1'b1);
        for (int k = 0; k < 5; k++) step(32'h300, 1'b1);

        // GHR repair beats a same-cycle speculative shift
        setRes(1'b1, 32'h3f0, 1, 1'b1, 32'h700, 0, 6'b101010, 1'b1);
        step(32'h40, 1'b0);
        setRes(1'b1, 32'h120, 0, 1'b1, 32'h900, 34, 0, 1'b0);
        step(32'h40, 1'b0);
        setRes(1'b1, 32'h120, 0, 1'b1, 32'h900, 34, 0, 1'b0);
        step(32'h40, 1'b0);
        setRes(1'b1, 32'h120, 0, 1'b0, 32'h0, 0, 6'b000011, 1'b1);
        step(32'h120, 1'b1);
        step(32'h120, 1'b0);

        // Asynchronous reset mid-cycle with a trained BTB entry under fetch
        pc_f_i = 32'h120;
        fetch_adv_f_i = 1'b0;
        idleRes();
        #2;
        reset_i = 1'b0;
        modelReset();
        begin
            exp_t e;
            bit   hit;
            int   typ;
            predict(32'h120, e, hit, typ);
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        step(32'h120, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            int unsigned fpc;
            int unsigned rpc;
            int          typ;
            fpc = 32'h1000 + 4 * $urandom_range(0, 15) + 128 * $urandom_range(0, 1);
            rpc = 32'h1000 + 4 * $urandom_range(0, 15) + 128 * $urandom_range(0, 1);
            typ = int'($urandom_range(0, 3));
            setRes($urandom_range(0, 2) != 0, rpc, typ, $urandom_range(0, 1) != 0,
                   {$urandom_range(0, 32'h3fff), 2'b00}, int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 63)), $urandom_range(0, 3) == 0);
            step(fpc, $urandom_range(0, 3) != 0);
        end

        for (int k = 0; k < 4 && expQ.size() > 0; k++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain cycle=%0d got=%0d want=0", cyc, expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
